// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB master arbiter: FSM encoding, latched request record,
// and the grant-index width helper.
package apb_master_arb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_arb_state_t;

    // Latched request; fields are sized for the fabric widths and narrower ports are cast.
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signal bundle for the APB master arbiter.
interface apb_master_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [ADDR_WIDTH-1:0]         paddr;
    logic [DATA_WIDTH-1:0]         pwdata;
    logic [DATA_WIDTH-1:0]         prdata;
    logic                          pready;
    logic                          pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
    import apb_master_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        int unsigned k;
        k         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = (32'(ptr) + i) % NUM_REQ;
            if (!any && req[k]) begin
                any       = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB3 master port among NUM_REQ requesters,
// with a pready stall timeout that forces an error completion.
module apb_master_arbiter
    import apb_master_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT    = 255
) (
    input logic                  clk,
    input logic                  rst,
    apb_master_arbiter_if.master bus
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, gnt_idx_q, arb_idx, next_ptr;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic                  arb_any;
    apb_req_t              lat_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  timed_out, access_done;
    logic                  psel_c, penable_c;
    logic [NUM_REQ-1:0]    req_ready_c;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (arb_gnt),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign addr_sel    = bus.req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_sel   = bus.req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    assign timed_out   = !bus.pready && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign access_done = bus.pready || timed_out;
    assign next_ptr    = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (access_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel_c      = 1'b0;
        penable_c   = 1'b0;
        req_ready_c = '0;
        case (state_q)
            IDLE:    if (!rst) req_ready_c = arb_gnt;
            SETUP:   psel_c = 1'b1;
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            lat_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: if (arb_any) begin
                    gnt_idx_q   <= arb_idx;
                    lat_q.write <= bus.req_write[arb_idx];
                    lat_q.addr  <= APB_ADDR_W'(addr_sel);
                    lat_q.wdata <= APB_DATA_W'(wdata_sel);
                    cnt_q       <= '0;
                end
                ACCESS: begin
                    if (!bus.pready) cnt_q <= cnt_q + CNT_W'(1);
                    // A timeout completes like a slave error but never returns bus data.
                    if (access_done) begin
                        rsp_valid_q <= NUM_REQ'(1) << gnt_idx_q;
                        rsp_rdata_q <= (bus.pready && !lat_q.write) ? bus.prdata : '0;
                        rsp_err_q   <= bus.pready ? bus.pslverr : 1'b1;
                        ptr_q       <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.psel      = psel_c;
    assign bus.penable   = penable_c;
    assign bus.pwrite    = lat_q.write;
    assign bus.paddr     = ADDR_WIDTH'(lat_q.addr);
    assign bus.pwdata    = DATA_WIDTH'(lat_q.wdata);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
